branch_predictor: RTL

- IF-stage dynamic branch predictor and branch target buffer (BTB). It supplies the next-PC prediction that the EX-stage branch resolution logic later checks.
- Looks up the fetch PC combinationally and produces PredictTaken and NextPC. PredictTaken is carried down the pipeline as the EX-stage "BranchTaken" input.
- Is trained by the EX-stage resolution outputs: ShouldBranch, BranchTargetAddr and PredictionMiss.
- Keeps saturating branch and mispredict statistics counters for performance checks.

---
 rtl/branch_predictor_pkg.sv | 31 +++
 rtl/branch_predictor_btb_entry_table.sv | 69 ++++++
 rtl/branch_predictor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared predictor definitions.
// Contents: the 2-bit counter encodings, the default PC width, and the
// saturating counter next-state function that trains the table.
package branch_predictor_pkg;

    localparam int PC_W_DEF = 16;

    // 2-bit counter encodings
    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    // Saturating up/down step of a 2-bit counter.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            {1'b1, CTR_SNT}: nxt = CTR_WNT;
            {1'b1, CTR_WNT}: nxt = CTR_WT;
            {1'b1, CTR_WT }: nxt = CTR_ST;
            {1'b1, CTR_ST }: nxt = CTR_ST;
            {1'b0, CTR_SNT}: nxt = CTR_SNT;
            {1'b0, CTR_WNT}: nxt = CTR_SNT;
            {1'b0, CTR_WT }: nxt = CTR_WNT;
            {1'b0, CTR_ST }: nxt = CTR_WT;
            default:         nxt = CTR_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_entry_table.sv
// btb_entry_table: registered BTB storage (valid, tag, target, 2-bit counter).
// Ports:
//   Clk, Reset          - clock and synchronous active-high reset
//   rd_a_*              - read port A (fetch lookup), combinational
//   rd_b_*              - read port B (update-side lookup), combinational
//   wr_en, wr_*         - single write port, committed on the rising edge
// Reset clears valid/tag/target and sets every counter to weakly not-taken.
module btb_entry_table
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = PC_W_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [IDX_W-1:0]        rd_a_idx,
    output logic                    rd_a_valid,
    output logic [PC_W-IDX_W-1:0]   rd_a_tag,
    output logic [PC_W-1:0]         rd_a_target,
    output logic [1:0]              rd_a_ctr,
    input  logic [IDX_W-1:0]        rd_b_idx,
    output logic                    rd_b_valid,
    output logic [PC_W-IDX_W-1:0]   rd_b_tag,
    output logic [PC_W-1:0]         rd_b_target,
    output logic [1:0]              rd_b_ctr,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic                    wr_valid,
    input  logic [PC_W-IDX_W-1:0]   wr_tag,
    input  logic [PC_W-1:0]         wr_target,
    input  logic [1:0]              wr_ctr
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W;

    logic             valid_r  [DEPTH];
    logic [TAG_W-1:0] tag_r    [DEPTH];
    logic [PC_W-1:0]  target_r [DEPTH];
    logic [1:0]       ctr_r    [DEPTH];

    // Table storage: reset has priority over any write in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {PC_W{1'b0}};
                ctr_r[i]    <= CTR_WNT;
            end
        end else if (wr_en) begin
            valid_r[wr_idx]  <= wr_valid;
            tag_r[wr_idx]    <= wr_tag;
            target_r[wr_idx] <= wr_target;
            ctr_r[wr_idx]    <= wr_ctr;
        end
    end

    assign rd_a_valid  = valid_r[rd_a_idx];
    assign rd_a_tag    = tag_r[rd_a_idx];
    assign rd_a_target = target_r[rd_a_idx];
    assign rd_a_ctr    = ctr_r[rd_a_idx];

    assign rd_b_valid  = valid_r[rd_b_idx];
    assign rd_b_tag    = tag_r[rd_b_idx];
    assign rd_b_target = target_r[rd_b_idx];
    assign rd_b_ctr    = ctr_r[rd_b_idx];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: IF-stage direction predictor + BTB with EX-stage training.
// Ports:
//   Clk, Reset                    - clock, synchronous active-high reset
//   PC_IF                         - fetch PC looked up combinationally
//   PredictTaken, NextPC          - prediction for the fetch PC
//   UpdateValid, UpdateJumpReg,
//   UpdatePC, ActualTaken,
//   ActualTarget, Mispredict      - resolved branch from EX
//   BranchCount, MissCount        - saturating statistics
// Lookups see pre-update state: a write lands one cycle after it is presented.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [PC_W-1:0]   PC_IF,
    output logic              PredictTaken,
    output logic [PC_W-1:0]   NextPC,
    input  logic              UpdateValid,
    input  logic              UpdateJumpReg,
    input  logic [PC_W-1:0]   UpdatePC,
    input  logic              ActualTaken,
    input  logic [PC_W-1:0]   ActualTarget,
    input  logic              Mispredict,
    output logic [CNT_W-1:0]  BranchCount,
    output logic [CNT_W-1:0]  MissCount
);

    localparam int TAG_W = PC_W - IDX_W;

    logic [IDX_W-1:0] look_idx_s;
    logic [TAG_W-1:0] look_tag_s;
    logic             look_valid_s;
    logic [TAG_W-1:0] look_etag_s;
    logic [PC_W-1:0]  look_target_s;
    logic [1:0]       look_ctr_s;
    logic             look_hit_s;
    logic             predict_s;

    logic [IDX_W-1:0] upd_idx_s;
    logic [TAG_W-1:0] upd_tag_s;
    logic             upd_valid_s;
    logic [TAG_W-1:0] upd_etag_s;
    logic [PC_W-1:0]  upd_target_s;
    logic [1:0]       upd_ctr_s;
    logic             upd_hit_s;

    logic             wr_en_s;
    logic             wr_valid_s;
    logic [TAG_W-1:0] wr_tag_s;
    logic [PC_W-1:0]  wr_target_s;
    logic [1:0]       wr_ctr_s;

    logic [CNT_W-1:0] branch_count_r;
    logic [CNT_W-1:0] miss_count_r;

    assign look_idx_s = PC_IF[IDX_W-1:0];
    assign look_tag_s = PC_IF[PC_W-1:IDX_W];
    assign upd_idx_s  = UpdatePC[IDX_W-1:0];
    assign upd_tag_s  = UpdatePC[PC_W-1:IDX_W];

    btb_entry_table #(
        .IDX_W (IDX_W),
        .PC_W  (PC_W)
    ) u_table (
        .Clk         (Clk),
        .Reset       (Reset),
        .rd_a_idx    (look_idx_s),
        .rd_a_valid  (look_valid_s),
        .rd_a_tag    (look_etag_s),
        .rd_a_target (look_target_s),
        .rd_a_ctr    (look_ctr_s),
        .rd_b_idx    (upd_idx_s),
        .rd_b_valid  (upd_valid_s),
        .rd_b_tag    (upd_etag_s),
        .rd_b_target (upd_target_s),
        .rd_b_ctr    (upd_ctr_s),
        .wr_en       (wr_en_s),
        .wr_idx      (upd_idx_s),
        .wr_valid    (wr_valid_s),
        .wr_tag      (wr_tag_s),
        .wr_target   (wr_target_s),
        .wr_ctr      (wr_ctr_s)
    );

    // Fetch lookup: taken only on a tag hit with a taken-leaning counter.
    always_comb begin
        look_hit_s = look_valid_s && (look_etag_s == look_tag_s);
        predict_s  = look_hit_s && ((look_ctr_s == CTR_WT) || (look_ctr_s == CTR_ST));
        if (predict_s) begin
            NextPC = look_target_s;
        end else begin
            NextPC = PC_IF + {{(PC_W-1){1'b0}}, 1'b1};  // wraps modulo 2**PC_W
        end
    end

    assign PredictTaken = predict_s;

    // Training: hits step the counter, taken misses allocate at weakly taken.
    // Register jumps never touch the table since their target is data-dependent.
    always_comb begin
        upd_hit_s   = upd_valid_s && (upd_etag_s == upd_tag_s);
        wr_en_s     = 1'b0;
        wr_valid_s  = 1'b1;
        wr_tag_s    = upd_tag_s;
        wr_target_s = upd_target_s;
        wr_ctr_s    = upd_ctr_s;
        if (UpdateValid && !UpdateJumpReg) begin
            if (upd_hit_s) begin
                wr_en_s     = 1'b1;
                wr_ctr_s    = ctr_next(upd_ctr_s, ActualTaken);
                wr_target_s = ActualTaken ? ActualTarget : upd_target_s;
            end else if (ActualTaken) begin
                wr_en_s     = 1'b1;
                wr_target_s = ActualTarget;
                wr_ctr_s    = CTR_WT;
            end else begin
                wr_en_s     = 1'b0;  // not-taken miss leaves any aliased entry alone
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Statistics counters, saturating at all-ones.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            branch_count_r <= {CNT_W{1'b0}};
            miss_count_r   <= {CNT_W{1'b0}};
        end else if (UpdateValid) begin
            if (branch_count_r != {CNT_W{1'b1}}) begin
                branch_count_r <= branch_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (Mispredict && (miss_count_r != {CNT_W{1'b1}})) begin
                miss_count_r <= miss_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign BranchCount = branch_count_r;
    assign MissCount   = miss_count_r;

endmodule
